// File: rtl/key_sw_io_responder.sv
// key_sw_io_responder: CPU-visible KEY/SW input registers.
// Synchronizes the pins and debounces the switches.
// Provides data and control/status registers with ready/overrun flags and an irq line.
module key_sw_io_responder #(
  parameter int unsigned      DBITS           = 32,
  parameter int unsigned      KEY_BITS        = 4,
  parameter int unsigned      SW_BITS         = 10,
  parameter int unsigned      DEBOUNCE_CYCLES = 100000,
  parameter logic [DBITS-1:0] ADDR_KDATA      = DBITS'(32'hF0000010),
  parameter logic [DBITS-1:0] ADDR_SDATA      = DBITS'(32'hF0000014),
  parameter logic [DBITS-1:0] ADDR_KCTRL      = DBITS'(32'hF0000110),
  parameter logic [DBITS-1:0] ADDR_SCTRL      = DBITS'(32'hF0000114)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [DBITS-1:0]    addr,
  input  logic                rd_en,
  input  logic                wr_en,
  input  logic [DBITS-1:0]    wr_data,
  output logic [DBITS-1:0]    rd_data,
  output logic                rd_hit,
  input  logic [KEY_BITS-1:0] key_in,
  input  logic [SW_BITS-1:0]  sw_in,
  output logic                irq
);

  localparam int unsigned     CntW   = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(DEBOUNCE_CYCLES - 1);

  // Synchronizers; key flops hold the inverted pin so that reset (0) means "not pressed".
  logic [KEY_BITS-1:0] key_meta_q, key_s_q;
  logic [SW_BITS-1:0]  sw_meta_q, sw_s_q;

  logic [KEY_BITS-1:0] kdata_q;
  logic [SW_BITS-1:0]  sdata_q, cand_q;
  logic [CntW-1:0]     cnt_q;

  logic kready_q, kovr_q, kie_q;
  logic sready_q, sovr_q, sie_q;
  logic kready_d, kovr_d, kie_d;
  logic sready_d, sovr_d, sie_d;

  logic sel_kdata, sel_sdata, sel_kctrl, sel_sctrl;
  logic rd_kdata, rd_sdata, wr_kctrl, wr_sctrl;
  logic key_evt, sw_commit;

  logic unused_wr;
  assign unused_wr = ^{wr_data[DBITS-1:9], wr_data[7:3], wr_data[1:0]};

  assign sel_kdata = (addr == ADDR_KDATA);
  assign sel_sdata = (addr == ADDR_SDATA);
  assign sel_kctrl = (addr == ADDR_KCTRL);
  assign sel_sctrl = (addr == ADDR_SCTRL);

  assign rd_kdata = rd_en & sel_kdata;
  assign rd_sdata = rd_en & sel_sdata;
  assign wr_kctrl = wr_en & sel_kctrl;
  assign wr_sctrl = wr_en & sel_sctrl;

  assign key_evt   = (key_s_q != kdata_q);
  // Commit only once the candidate has been stable for the full window and differs from sdata.
  assign sw_commit = (sw_s_q == cand_q) && (cnt_q == CntMax) && (cand_q != sdata_q);

  // Two-flop synchronizers for all pins.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      key_meta_q <= '0;
      key_s_q    <= '0;
      sw_meta_q  <= '0;
      sw_s_q     <= '0;
    end else begin
      key_meta_q <= ~key_in;
      key_s_q    <= key_meta_q;
      sw_meta_q  <= sw_in;
      sw_s_q     <= sw_meta_q;
    end
  end

  // Key data follows the synchronized pins every cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      kdata_q <= '0;
    end else begin
      kdata_q <= key_s_q;
    end
  end

  // Switch debounce: any difference from the candidate restarts the shared counter.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cand_q  <= '0;
      cnt_q   <= '0;
      sdata_q <= '0;
    end else begin
      if (sw_s_q != cand_q) begin
        cand_q <= sw_s_q;
        cnt_q  <= '0;
      end else if (cnt_q != CntMax) begin
        cnt_q <= cnt_q + CntW'(1);
      end
      if (sw_commit) begin
        sdata_q <= cand_q;
      end
    end
  end

  // Status next state: a new event beats a data read (ready) and beats an ovr clear.
  always_comb begin
    kready_d = kready_q;
    kovr_d   = kovr_q;
    kie_d    = kie_q;
    sready_d = sready_q;
    sovr_d   = sovr_q;
    sie_d    = sie_q;

    if (wr_kctrl) begin
      kie_d = wr_data[8];
      if (!wr_data[2]) kovr_d = 1'b0;
    end
    if (rd_kdata) kready_d = 1'b0;
    if (key_evt) begin
      kready_d = 1'b1;
      // A simultaneous read consumed the previous value, so it was not overrun.
      if (kready_q && !rd_kdata) kovr_d = 1'b1;
    end

    if (wr_sctrl) begin
      sie_d = wr_data[8];
      if (!wr_data[2]) sovr_d = 1'b0;
    end
    if (rd_sdata) sready_d = 1'b0;
    if (sw_commit) begin
      sready_d = 1'b1;
      if (sready_q && !rd_sdata) sovr_d = 1'b1;
    end
  end

  // Status registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      kready_q <= 1'b0;
      kovr_q   <= 1'b0;
      kie_q    <= 1'b0;
      sready_q <= 1'b0;
      sovr_q   <= 1'b0;
      sie_q    <= 1'b0;
    end else begin
      kready_q <= kready_d;
      kovr_q   <= kovr_d;
      kie_q    <= kie_d;
      sready_q <= sready_d;
      sovr_q   <= sovr_d;
      sie_q    <= sie_d;
    end
  end

  // Load mux; forced to zero while reset is asserted.
  always_comb begin
    rd_data = '0;
    rd_hit  = 1'b0;
    if (rd_en && reset) begin
      rd_hit = sel_kdata | sel_sdata | sel_kctrl | sel_sctrl;
      if (sel_kdata) begin
        rd_data[KEY_BITS-1:0] = kdata_q;
      end else if (sel_sdata) begin
        rd_data[SW_BITS-1:0] = sdata_q;
      end else if (sel_kctrl) begin
        rd_data[8] = kie_q;
        rd_data[2] = kovr_q;
        rd_data[0] = kready_q;
      end else if (sel_sctrl) begin
        rd_data[8] = sie_q;
        rd_data[2] = sovr_q;
        rd_data[0] = sready_q;
      end
    end
  end

  assign irq = (kready_q & kie_q) | (sready_q & sie_q);

endmodule

// File: tb/tb_key_sw_io_responder.sv
// Randomized scoreboard bench for key_sw_io_responder with DEBOUNCE_CYCLES=8.
module tb_key_sw_io_responder;

  localparam int D = 8;
  localparam logic [31:0] KDATA = 32'hF0000010;
  localparam logic [31:0] SDATA = 32'hF0000014;
  localparam logic [31:0] KCTRL = 32'hF0000110;
  localparam logic [31:0] SCTRL = 32'hF0000114;
  localparam logic [31:0] UNMAP = 32'hF0000018;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] addr;
  logic        rd_en, wr_en;
  logic [31:0] wr_data;
  logic [31:0] rd_data;
  logic        rd_hit;
  logic [3:0]  key_in;
  logic [9:0]  sw_in;
  logic        irq;

  key_sw_io_responder #(
    .DEBOUNCE_CYCLES(D)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .addr   (addr),
    .rd_en  (rd_en),
    .wr_en  (wr_en),
    .wr_data(wr_data),
    .rd_data(rd_data),
    .rd_hit (rd_hit),
    .key_in (key_in),
    .sw_in  (sw_in),
    .irq    (irq)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        hit;
    logic [31:0] data;
    logic        irq;
  } exp_t;

  exp_t exp_q[$];
  int checks = 0;
  int errors = 0;

  // Reference model: pin sample delay lines, plain stability run length, flags.
  logic [3:0] kq[$];
  logic [9:0] sq[$];
  logic [3:0] m_kdata;
  logic [9:0] m_sdata, m_cand;
  int         m_stable;
  logic       m_kready, m_kovr, m_kie, m_sready, m_sovr, m_sie;

  task automatic model_reset();
    kq = '{4'h0, 4'h0};
    sq = '{10'h0, 10'h0};
    m_kdata = '0; m_sdata = '0; m_cand = '0; m_stable = 0;
    m_kready = 0; m_kovr = 0; m_kie = 0;
    m_sready = 0; m_sovr = 0; m_sie = 0;
  endtask

  function automatic logic is_mapped(input logic [31:0] a);
    return (a == KDATA) || (a == SDATA) || (a == KCTRL) || (a == SCTRL);
  endfunction

  function automatic logic [31:0] reg_value(input logic [31:0] a);
    if (a == KDATA) return {28'd0, m_kdata};
    if (a == SDATA) return {22'd0, m_sdata};
    if (a == KCTRL) return {23'd0, m_kie, 5'd0, m_kovr, 1'b0, m_kready};
    if (a == SCTRL) return {23'd0, m_sie, 5'd0, m_sovr, 1'b0, m_sready};
    return 32'd0;
  endfunction

  // Returns {ie, ovr, ready} after one edge.
  function automatic logic [2:0] status_next(input logic ev, input logic rd, input logic wr,
                                             input logic [31:0] wd, input logic rdy,
                                             input logic ovr, input logic ie);
    logic rdy_n, ovr_n, ie_n;
    ie_n  = wr ? wd[8] : ie;
    ovr_n = (wr && !wd[2]) ? 1'b0 : ovr;
    if (ev && rdy && !rd) ovr_n = 1'b1;
    rdy_n = ev ? 1'b1 : (rd ? 1'b0 : rdy);
    return {ie_n, ovr_n, rdy_n};
  endfunction

  task automatic model_edge(input logic [31:0] a, input logic r, input logic w,
                            input logic [31:0] wd, input logic [3:0] kin, input logic [9:0] sin);
    logic [3:0] ks;
    logic [9:0] ss;
    logic kev, sev;
    logic [2:0] kn, sn;
    ks = kq.pop_front();
    kq.push_back(~kin);
    ss = sq.pop_front();
    sq.push_back(sin);
    kev = (ks != m_kdata);
    m_kdata = ks;
    sev = 1'b0;
    if (ss != m_cand) begin
      m_cand = ss;
      m_stable = 0;
    end else begin
      if (m_stable >= D - 1 && m_cand != m_sdata) begin
        sev = 1'b1;
        m_sdata = m_cand;
      end
      m_stable++;
    end
    kn = status_next(kev, r && a == KDATA, w && a == KCTRL, wd, m_kready, m_kovr, m_kie);
    sn = status_next(sev, r && a == SDATA, w && a == SCTRL, wd, m_sready, m_sovr, m_sie);
    {m_kie, m_kovr, m_kready} = kn;
    {m_sie, m_sovr, m_sready} = sn;
  endtask

  // One bus cycle: push the expected outputs, then advance the model across the edge.
  task automatic cycle(input logic [31:0] a, input logic r, input logic w, input logic [31:0] wd);
    exp_t e;
    addr = a; rd_en = r; wr_en = w; wr_data = wd;
    e.hit  = reset && r && is_mapped(a);
    e.data = e.hit ? reg_value(a) : 32'd0;
    e.irq  = (m_kready & m_kie) | (m_sready & m_sie);
    exp_q.push_back(e);
    @(posedge clk);
    if (reset) model_edge(a, r, w, wd, key_in, sw_in);
    #1;
  endtask

  task automatic rd(input logic [31:0] a);
    cycle(a, 1'b1, 1'b0, 32'd0);
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    cycle(a, 1'b0, 1'b1, d);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(KCTRL, 1'b0, 1'b0, 32'd0);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: compares DUT outputs against the oldest queued expectation each cycle.
  exp_t mon_e;
  always @(negedge clk) begin
    if (exp_q.size() != 0) begin
      mon_e = exp_q.pop_front();
      check("rd_hit", {31'd0, rd_hit}, {31'd0, mon_e.hit});
      check("rd_data", rd_data, mon_e.data);
      check("irq", {31'd0, irq}, {31'd0, mon_e.irq});
    end
  end

  function automatic logic [31:0] pick_addr();
    case ($urandom_range(0, 5))
      0: return KDATA;
      1: return SDATA;
      2: return KCTRL;
      3: return SCTRL;
      4: return UNMAP;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    reset = 1'b0; addr = '0; rd_en = 0; wr_en = 0; wr_data = '0;
    key_in = 4'hF; sw_in = '0;
    model_reset();
    @(posedge clk); #1;

    // 1: pins wiggle under reset, loads must return nothing.
    for (int i = 0; i < 4; i++) begin
      key_in = 4'($urandom); sw_in = 10'($urandom);
      rd(i[0] ? KCTRL : SDATA);
    end
    key_in = 4'hF; sw_in = '0;
    idle(1);
    reset = 1'b1;
    idle(3);
    rd(KCTRL);

    // 2: single key press.
    key_in = 4'hE;
    idle(3);
    rd(KCTRL);
    rd(KDATA);
    rd(KCTRL);

    // 3: switch change, then a bounce on bit0 restarting the window.
    sw_in = 10'h2A5;
    for (int i = 0; i < 12; i++) rd(SDATA);
    sw_in = 10'h2A4;
    rd(SCTRL);
    sw_in = 10'h2A5;
    for (int i = 0; i < 14; i++) rd(SCTRL);
    rd(SDATA);

    // 4: overrun, clear by store of 0, store of 1 to bit2 ignored.
    key_in = 4'hC; idle(4);
    key_in = 4'h8; idle(4);
    rd(KCTRL);
    wr(KCTRL, 32'h0); rd(KCTRL);
    wr(KCTRL, 32'h4); rd(KCTRL);

    // 5: switch interrupt enable.
    wr(SCTRL, 32'h100);
    sw_in = 10'h155;
    for (int i = 0; i < 13; i++) rd(SCTRL);
    rd(SDATA);
    idle(2);
    wr(SCTRL, 32'h0);

    // 6: key event coinciding with a KDATA read while ready=1, then unmapped load.
    key_in = 4'h0;
    idle(2);
    rd(KDATA);
    rd(KCTRL);
    rd(UNMAP);

    // Randomized traffic with quiet and noisy switch phases and one mid-run reset.
    for (int i = 0; i < 700; i++) begin
      if (i == 350) begin
        reset = 1'b0;
        model_reset();
        idle(3);
        reset = 1'b1;
      end
      if ($urandom_range(0, 11) == 0) key_in = 4'($urandom);
      if (((i / 40) % 2) == 1) begin
        if ($urandom_range(0, 2) == 0) sw_in[$urandom_range(0, 9)] ^= 1'b1;
      end else if ($urandom_range(0, 39) == 0) begin
        sw_in = 10'($urandom);
      end
      cycle(pick_addr(), 1'($urandom), $urandom_range(0, 3) == 0, $urandom);
    end

    idle(1);
    @(negedge clk); #1;
    check("queue_drained", exp_q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
